// File: rtl/nibble_serial_addsub_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
// Holds the FSM state encoding and the digit width of the shared adder.
package nibble_serial_addsub_ctrl_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_addsub_ctrl_adder.sv
// The existing 4-bit Addition block, time-shared by the sequencer.
// It is purely combinational: {Cout, Result} = A + B + Cin.
module nibble_serial_addsub_ctrl_adder
    import nibble_serial_addsub_ctrl_pkg::*;
(
    input  logic [DIGIT_W-1:0] A,
    input  logic [DIGIT_W-1:0] B,
    input  logic               Cin,
    output logic [DIGIT_W-1:0] Result,
    output logic               Cout
);

    assign {Cout, Result} = {1'b0, A} + {1'b0, B} + {{DIGIT_W{1'b0}}, Cin};

endmodule

// File: rtl/nibble_serial_addsub_ctrl.sv
// Wide add/subtract that feeds one nibble per cycle, LSB first, through a single
// 4-bit adder, with the carry registered between nibbles.
module nibble_serial_addsub_ctrl
    import nibble_serial_addsub_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       sub,
    input  logic [DIGIT_W*NIBBLES-1:0] a,
    input  logic [DIGIT_W*NIBBLES-1:0] b,
    output logic                       busy,
    output logic                       done,
    output logic [DIGIT_W*NIBBLES-1:0] result,
    output logic                       cout,
    output logic                       ovf
);

    localparam int W     = DIGIT_W * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   idx;
    logic [W-1:0]       opa;
    logic [W-1:0]       opb;
    logic               carry_reg;
    logic [DIGIT_W-1:0] nib_sum;
    logic               nib_cout;
    logic               accept;
    logic               last;

    // Operands are shifted right each RUN edge, so the current nibble is
    // always the low nibble and the MSB nibble sits there on the final edge.
    nibble_serial_addsub_ctrl_adder u_adder (
        .A      (opa[DIGIT_W-1:0]),
        .B      (opb[DIGIT_W-1:0]),
        .Cin    (carry_reg),
        .Result (nib_sum),
        .Cout   (nib_cout)
    );

    assign accept = start && (state == ST_IDLE || state == ST_DONE);
    assign last   = (idx == IDX_W'(NIBBLES - 1));

    // busy and done are decodes of the state register only.
    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default first so no branch leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (last)  state_next = ST_DONE;
            ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: operand shifters are reset too, keeping X out of the adder in simulation.
        if (!rst_n) begin
            idx       <= '0;
            opa       <= '0;
            opb       <= '0;
            carry_reg <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (accept) begin
            idx       <= '0;
            opa       <= a;
            opb       <= sub ? ~b : b;
            carry_reg <= sub;
            result    <= '0;
        end else if (state == ST_RUN) begin
            opa       <= opa >> DIGIT_W;
            opb       <= opb >> DIGIT_W;
            carry_reg <= nib_cout;
            for (int i = 0; i < NIBBLES; i++) begin
                if (idx == IDX_W'(i)) result[i*DIGIT_W +: DIGIT_W] <= nib_sum;
            end
            if (last) begin
                cout <= nib_cout;
                ovf  <= (opa[DIGIT_W-1] == opb[DIGIT_W-1]) &&
                        (nib_sum[DIGIT_W-1] != opa[DIGIT_W-1]);
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Directed self-checking bench for nibble_serial_addsub_ctrl (NIBBLES=4).
// Outputs are sampled 1 time unit after each rising edge.
module tb_nibble_serial_addsub_ctrl;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int total = 0;
    int bad   = 0;

    nibble_serial_addsub_ctrl #(.NIBBLES(NIB)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; returns in cycle 1 of the operation.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts);
        a     = ta;
        b     = tb;
        sub   = ts;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called in cycle 1; returns in the cycle where done is seen (or the bound expires).
    task automatic wait_done(input string tag);
        int cyc = 1;
        while (done !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_lat"}, cyc, NIB + 1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic ts, input logic [W-1:0] er, input logic ec, input logic ev);
        start_op(ta, tb, ts);
        check({tag, "_busy1"}, busy, 1);
        wait_done(tag);
        check({tag, "_busy_done"}, busy, 0);
        check({tag, "_res"}, result, er);
        check({tag, "_cout"}, cout, ec);
        check({tag, "_ovf"}, ovf, ev);
        tick();
        check({tag, "_pulse"}, done, 0);
        check({tag, "_hold"}, result, er);
    endtask

    initial begin
        logic saw_done;
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_res", result, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        tick();

        run_op("add",    16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0);
        run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);

        // Start pulses in RUN cycles 2 and 3 must be ignored.
        start_op(16'h1234, 16'h0FCD, 1'b0);
        tick();
        a = 16'h1111; b = 16'h2222; sub = 1'b1; start = 1'b1;
        tick();
        a = 16'h3333; b = 16'h0444;
        tick();
        start = 1'b0;
        check("prot_busy4", busy, 1);
        tick();
        check("prot_done", done, 1);
        check("prot_res", result, 16'h2201);
        check("prot_cout", cout, 0);
        check("prot_ovf", ovf, 0);
        // Back-to-back: start in the DONE cycle.
        start_op(16'h0003, 16'h0004, 1'b0);
        check("b2b_busy", busy, 1);
        check("b2b_done", done, 0);
        check("b2b_clr", result, 0);
        wait_done("b2b");
        check("b2b_res", result, 16'h0007);
        tick();

        // Leaves cout=1, ovf=1 so the reset check below is meaningful.
        run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Reset for one edge in the middle of RUN.
        start_op(16'hAAAA, 16'h1111, 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_res", result, 0);
        check("mid_cout", cout, 0);
        check("mid_ovf", ovf, 0);
        saw_done = 1'b0;
        for (int i = 0; i < 2 * NIB; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        check("mid_quiet", saw_done, 0);
        run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
